// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - two-port writeback arbiter for reg_bank with RAW hazard detect (optional REG_WB_BYPASS_EN forwarding)
module reg_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [ADDR_W-1:0] rb_dirwrite,
    output logic [DATA_W-1:0] rb_datawrite,
    output logic              rb_memwrite,
    output logic              rb_memread,
`ifdef REG_WB_BYPASS_EN
    input  logic [DATA_W-1:0] bank_a,
    input  logic [DATA_W-1:0] bank_b,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
`endif
    output logic              hazard
);

    logic              buf0_full_q, buf0_full_d;
    logic [ADDR_W-1:0] buf0_addr_q, buf0_addr_d;
    logic [DATA_W-1:0] buf0_data_q, buf0_data_d;
    logic              buf1_full_q, buf1_full_d;
    logic [ADDR_W-1:0] buf1_addr_q, buf1_addr_d;
    logic [DATA_W-1:0] buf1_data_q, buf1_data_d;
    logic              rr_q, rr_d;
    logic              rb_memwrite_q, rb_memwrite_d;
    logic              rb_memread_q, rb_memread_d;
    logic [ADDR_W-1:0] rb_dirwrite_q, rb_dirwrite_d;
    logic [DATA_W-1:0] rb_datawrite_q, rb_datawrite_d;

    logic grant0, grant1;
    logic load0, load1;

    // Round-robin grant: a lone full buffer wins, contention goes to the rr port
    always_comb begin
        grant0 = buf0_full_q && (!buf1_full_q || !rr_q);
        grant1 = buf1_full_q && (!buf0_full_q || rr_q);
    end

    assign wr0_ready = !buf0_full_q || grant0;
    assign wr1_ready = !buf1_full_q || grant1;

    // Writes to register 0 complete the handshake but never occupy a buffer
    assign load0 = wr0_valid && wr0_ready && (wr0_addr != '0);
    assign load1 = wr1_valid && wr1_ready && (wr1_addr != '0);

    // Next state for the holding buffers, rr pointer and registered write port
    always_comb begin
        buf0_full_d    = buf0_full_q;
        buf0_addr_d    = buf0_addr_q;
        buf0_data_d    = buf0_data_q;
        buf1_full_d    = buf1_full_q;
        buf1_addr_d    = buf1_addr_q;
        buf1_data_d    = buf1_data_q;
        rr_d           = rr_q;
        rb_memwrite_d  = grant0 || grant1;
        rb_memread_d   = 1'b1;
        rb_dirwrite_d  = rb_dirwrite_q;
        rb_datawrite_d = rb_datawrite_q;

        if (load0) begin
            buf0_full_d = 1'b1;
            buf0_addr_d = wr0_addr;
            buf0_data_d = wr0_data;
        end else if (grant0) begin
            buf0_full_d = 1'b0;
        end

        if (load1) begin
            buf1_full_d = 1'b1;
            buf1_addr_d = wr1_addr;
            buf1_data_d = wr1_data;
        end else if (grant1) begin
            buf1_full_d = 1'b0;
        end

        // Pointer only moves when both buffers competed this cycle
        if (buf0_full_q && buf1_full_q) begin
            rr_d = !rr_q;
        end

        if (grant0) begin
            rb_dirwrite_d  = buf0_addr_q;
            rb_datawrite_d = buf0_data_q;
        end else if (grant1) begin
            rb_dirwrite_d  = buf1_addr_q;
            rb_datawrite_d = buf1_data_q;
        end
    end

    // State registers; async reset discards any pending writes at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_full_q    <= 1'b0;
            buf0_addr_q    <= '0;
            buf0_data_q    <= '0;
            buf1_full_q    <= 1'b0;
            buf1_addr_q    <= '0;
            buf1_data_q    <= '0;
            rr_q           <= 1'b0;
            rb_memwrite_q  <= 1'b0;
            rb_memread_q   <= 1'b0;
            rb_dirwrite_q  <= '0;
            rb_datawrite_q <= '0;
        end else begin
            buf0_full_q    <= buf0_full_d;
            buf0_addr_q    <= buf0_addr_d;
            buf0_data_q    <= buf0_data_d;
            buf1_full_q    <= buf1_full_d;
            buf1_addr_q    <= buf1_addr_d;
            buf1_data_q    <= buf1_data_d;
            rr_q           <= rr_d;
            rb_memwrite_q  <= rb_memwrite_d;
            rb_memread_q   <= rb_memread_d;
            rb_dirwrite_q  <= rb_dirwrite_d;
            rb_datawrite_q <= rb_datawrite_d;
        end
    end

    assign rb_memwrite  = rb_memwrite_q;
    assign rb_memread   = rb_memread_q;
    assign rb_dirwrite  = rb_dirwrite_q;
    assign rb_datawrite = rb_datawrite_q;

`ifdef REG_WB_BYPASS_EN
    // Newest pending value for a read address: buffers beat the output register,
    // and when both buffers match, the one granted second (not at rr) is newer
    function automatic logic [DATA_W-1:0] fwd_pick(input logic [ADDR_W-1:0] ra,
                                                   input logic [DATA_W-1:0] bank);
        logic m0, m1, mo;
        m0 = buf0_full_q && (buf0_addr_q == ra);
        m1 = buf1_full_q && (buf1_addr_q == ra);
        mo = rb_memwrite_q && (rb_dirwrite_q == ra);
        if (ra == '0)        fwd_pick = bank;
        else if (m0 && m1)   fwd_pick = rr_q ? buf0_data_q : buf1_data_q;
        else if (m1)         fwd_pick = buf1_data_q;
        else if (m0)         fwd_pick = buf0_data_q;
        else if (mo)         fwd_pick = rb_datawrite_q;
        else                 fwd_pick = bank;
    endfunction

    // Forwarded read data; grant order always ranks two matching buffers, so no stall is needed
    always_comb begin
        fwd_a  = fwd_pick(rd_a_addr, bank_a);
        fwd_b  = fwd_pick(rd_b_addr, bank_b);
        hazard = 1'b0;
    end
`else
    function automatic logic pending_match(input logic [ADDR_W-1:0] ra);
        pending_match = (ra != '0) &&
                        ((buf0_full_q && (buf0_addr_q == ra)) ||
                         (buf1_full_q && (buf1_addr_q == ra)) ||
                         (rb_memwrite_q && (rb_dirwrite_q == ra)));
    endfunction

    // Stall request while either read address targets an uncommitted write
    always_comb begin
        hazard = pending_match(rd_a_addr) || pending_match(rd_b_addr);
    end
`endif

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the register bank (`reg_bank`) between two writeback requesters:
  - port 0: ALU result;
  - port 1: load/memory result.
- Each requester has a 1-entry holding buffer. A round-robin arbiter drains the buffers into a registered write port driving `reg_bank` dirwrite/datawrite/memwrite.
- Also flags read-after-write hazards for the bank's two read addresses, so the pipeline controller can stall.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- wr0_valid  in  1  requester 0 write request.
- wr0_addr  in  ADDR_W  requester 0 destination register.
- wr0_data  in  DATA_W  requester 0 write data.
- wr0_ready  out  1  requester 0 may present a new write.
- wr1_valid  in  1  requester 1 write request.
- wr1_addr  in  ADDR_W  requester 1 destination register.
- wr1_data  in  DATA_W  requester 1 write data.
- wr1_ready  out  1  requester 1 may present a new write.
- rd_a_addr  in  ADDR_W  current `reg_bank` dira.
- rd_b_addr  in  ADDR_W  current `reg_bank` dirb.
- rb_dirwrite  out  ADDR_W  to `reg_bank` dirwrite (registered).
- rb_datawrite  out  DATA_W  to `reg_bank` datawrite (registered).
- rb_memwrite  out  1  to `reg_bank` memwrite (registered).
- rb_memread  out  1  to `reg_bank` memread (registered).
- hazard  out  1  a read address matches a not-yet-committed write.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - buf0_full = buf1_full = 0; rr pointer = 0 (port 0 preferred first).
  - rb_memwrite = 0, rb_memread = 0, rb_dirwrite = 0, rb_datawrite = 0.
  - hazard = 0; wr0_ready = wr1_ready = 1 once rst deasserts.
- rb_memread: 1 on every edge after reset.
- Accept: on an edge with wrN_valid && wrN_ready, bufN loads {addr, data} and full is set.
- Zero register: if wrN_addr == 0, the write is accepted (handshake completes) and dropped. The buffer does not fill and no bank write occurs.
- Grant (combinational):
  - Only one buffer full: that buffer wins.
  - Both full: the port at rr wins; rr flips to the other port on that edge.
  - rr changes only on a contended grant.
- Issue: on the edge after a grant:
  - rb_memwrite = 1; rb_dirwrite/rb_datawrite = winner's buffer contents.
  - The winner's full flag clears, unless it reloads on the same edge.
  - With no grant, rb_memwrite = 0 and the address/data outputs hold their last values.
- Ready: wrN_ready = !bufN_full || grantN. A buffer granted this cycle may accept a new write on the same edge, giving 1 write/cycle sustained throughput per port when uncontended.
- Latency: accept at edge E, rb_memwrite high after edge E+1, `reg_bank` commits at edge E+2.
- Simultaneous accepts on both ports: both buffers fill. The next grant goes to rr, and the other port issues one cycle later.
- Same-address writes in both buffers: issue order follows grant order; no merging. The last issued value wins.
- hazard (combinational): 1 if rd_a_addr or rd_b_addr is nonzero and equals any of:
  - buf0 address (buf0 full);
  - buf1 address (buf1 full);
  - rb_dirwrite (rb_memwrite = 1).
- Reset mid-operation: pending buffered writes are discarded and rb_memwrite drops immediately (asynchronous reset). No partial write reaches the bank after rst rises.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined — added ports:
  - bank_a / bank_b (in, DATA_W): `reg_bank` a/b outputs.
  - fwd_a / fwd_b (out, DATA_W): forwarded read data.
- Defined — forwarding behaviour:
  - fwd_x = newest pending data matching rd_x_addr. Priority: buffers over the output register; between buffers, the port that would be granted later is newer. Otherwise fwd_x = bank_x.
  - hazard asserts only when both buffers hold a matching address with no resolvable order at the same time; otherwise hazard = 0.
- Undefined: no extra ports; hazard behaves as in Behaviour.

Test Plan:
- Single write, reg 5:
  - Stimulus: reset, then wr0 {addr 5, data 54} for one cycle.
  - Response: rb_memwrite = 1 with rb_dirwrite = 5, rb_datawrite = 54 exactly one cycle after accept; then rb_memwrite = 0.
  - Readback: subsequent `reg_bank` read of dira = 5 returns 54.
- Contention:
  - Stimulus: wr0 {8, 4} and wr1 {9, 7} on the same edge.
  - Response: issue of 8/4 first, then 9/7 on the next cycle.
  - Repeat the pair: 9-side (port 1) issues first, proving rr rotation.
- Back-to-back:
  - Stimulus: wr0 continuously valid with addrs 1, 2, 3, 4 and data 10, 20, 30, 40; no port-1 traffic.
  - Response: wr0_ready stays 1; four consecutive rb_memwrite pulses in order.
- Zero register:
  - Stimulus: wr1 {0, 0xDEAD}.
  - Response: wr1_ready = 1; handshake completes; rb_memwrite never asserts.
- Hazard:
  - Stimulus: wr0 {8, 4} held in buffer, rd_a_addr = 8.
  - Response: hazard = 1 until the cycle after rb_memwrite drops.
  - Stimulus: rd_a_addr = 0.
  - Response: hazard = 0.
  - With REG_WB_BYPASS_EN defined: hazard = 0 and fwd_a = 4 throughout.
- Reset mid-operation:
  - Stimulus: both buffers full, assert rst mid-cycle.
  - Response: rb_memwrite = 0 immediately; both readies = 1 after release; no later bank writes.
